// File: rtl/i2c_master_ctrl_if.sv
// Command/response handshake and I2C pin bundle between the AXI-side register
// logic, the single-byte I2C master sequencer and the open-drain bus.
interface i2c_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_nack;
  logic       busy;
  logic       m_scl_o;
  logic       m_sda_i;
  logic       m_sda_o;
  logic       m_sda_o_en;

  modport master (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, m_sda_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy,
           m_scl_o, m_sda_o, m_sda_o_en
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, m_sda_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy,
           m_scl_o, m_sda_o, m_sda_o_en
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, ACK, one data byte, ACK, STOP.
// Each bit period is four quarters of CLK_DIV clocks; SCL and SDA enable are registered.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  i2c_master_ctrl_if.master bus
);

  localparam int             QW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]  QC_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, STOP, DONE
  } state_t;

  state_t        r_state;
  logic [QW-1:0] r_qc;
  logic [1:0]    r_q;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_wdata;
  logic          r_rw;
  logic [7:0]    r_rdata;
  logic [1:0]    r_nack;
  logic          r_rsp_valid;
  logic          r_scl;
  logic          r_sda_en;

  state_t        w_nxt_state;
  logic [QW-1:0] w_nxt_qc;
  logic [1:0]    w_nxt_q;
  logic [2:0]    w_nxt_bit_cnt;
  logic [7:0]    w_nxt_shift;
  logic          w_accept;
  logic          w_q_end;
  logic          w_period_end;
  logic          w_sample;
  logic          w_addr_nack;

  // Pin levels are a pure function of where we are inside the bit period.
  function automatic logic scl_of(input state_t s, input logic [1:0] q);
    case (s)
      IDLE, DONE, START: scl_of = 1'b1;
      default:           scl_of = q[1];
    endcase
  endfunction

  function automatic logic sda_en_of(input state_t s, input logic [1:0] q, input logic b);
    case (s)
      START:        sda_en_of = q[1];
      ADDR, WDATA:  sda_en_of = ~b;
      STOP:         sda_en_of = (q != 2'd3);
      default:      sda_en_of = 1'b0;
    endcase
  endfunction

  assign w_accept     = (r_state == IDLE) && bus.cmd_valid;
  assign w_q_end      = (r_qc == QC_LAST);
  assign w_period_end = w_q_end && (r_q == 2'd3);
  assign w_sample     = (r_qc == '0) && (r_q == 2'd3);
  // With CLK_DIV=1 the ACK sample and the period end share one edge.
  assign w_addr_nack  = r_nack[0] | (w_sample & bus.m_sda_i);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_nxt_state   = r_state;
    w_nxt_qc      = r_qc;
    w_nxt_q       = r_q;
    w_nxt_bit_cnt = r_bit_cnt;
    w_nxt_shift   = r_shift;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_state   = START;
          w_nxt_qc      = '0;
          w_nxt_q       = '0;
          w_nxt_bit_cnt = '0;
          w_nxt_shift   = {bus.cmd_addr, bus.cmd_rw};
        end
      end
      DONE: w_nxt_state = IDLE;
      default: begin
        if (w_q_end) begin
          w_nxt_qc = '0;
          w_nxt_q  = r_q + 2'd1;
        end else begin
          w_nxt_qc = r_qc + QW'(1);
        end
        if (w_period_end) begin
          w_nxt_bit_cnt = r_bit_cnt + 3'd1;
          case (r_state)
            START: begin
              w_nxt_state   = ADDR;
              w_nxt_bit_cnt = '0;
            end
            ADDR: begin
              w_nxt_shift = {r_shift[6:0], 1'b0};
              if (r_bit_cnt == 3'd7) w_nxt_state = ACK1;
            end
            ACK1: begin
              w_nxt_bit_cnt = '0;
              if (w_addr_nack)  w_nxt_state = STOP;
              else if (r_rw)    w_nxt_state = RDATA;
              else begin
                w_nxt_state = WDATA;
                w_nxt_shift = r_wdata;
              end
            end
            WDATA: begin
              w_nxt_shift = {r_shift[6:0], 1'b0};
              if (r_bit_cnt == 3'd7) w_nxt_state = ACK2;
            end
            RDATA:   if (r_bit_cnt == 3'd7) w_nxt_state = ACK2;
            ACK2:    w_nxt_state = STOP;
            STOP:    w_nxt_state = DONE;
            default: w_nxt_state = r_state;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= IDLE;
      r_qc        <= '0;
      r_q         <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_wdata     <= '0;
      r_rw        <= 1'b0;
      r_rdata     <= '0;
      r_nack      <= '0;
      r_rsp_valid <= 1'b0;
      r_scl       <= 1'b1;
      r_sda_en    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      r_state     <= w_nxt_state;
      r_qc        <= w_nxt_qc;
      r_q         <= w_nxt_q;
      r_bit_cnt   <= w_nxt_bit_cnt;
      r_shift     <= w_nxt_shift;
      r_rsp_valid <= (w_nxt_state == DONE);
      r_scl       <= scl_of(w_nxt_state, w_nxt_q);
      r_sda_en    <= sda_en_of(w_nxt_state, w_nxt_q, w_nxt_shift[7]);
      if (w_accept) begin
        r_wdata <= bus.cmd_wdata;
        r_rw    <= bus.cmd_rw;
        r_rdata <= '0;
        r_nack  <= '0;
      end
      if (w_sample) begin
        if (r_state == RDATA)                          r_rdata   <= {r_rdata[6:0], bus.m_sda_i};
        if (r_state == ACK1 && bus.m_sda_i)            r_nack[0] <= 1'b1;
        if (r_state == ACK2 && !r_rw && bus.m_sda_i)   r_nack[1] <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_nack   = r_nack;
  assign bus.m_scl_o    = r_scl;
  assign bus.m_sda_o    = 1'b0;
  assign bus.m_sda_o_en = r_sda_en;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bit-level slave on the open-drain bus, a transaction-level
// expectation model, and directed plus random command sequences.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 2;

  logic CLK = 1'b0;
  logic RESETn;
  logic s_pull = 1'b0;
  logic bus_sda;

  i2c_master_ctrl_if bus_if ();

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus_if.master)
  );

  always #5 CLK = ~CLK;

  // Pulled-up wire: low if either side pulls.
  assign bus_sda        = ~(bus_if.m_sda_o_en | s_pull);
  assign bus_if.m_sda_i = bus_sda;

  int total = 0;
  int bad   = 0;

  // Slave configuration, set by the main thread between transactions.
  logic [6:0] s_addr;
  logic [7:0] s_rdata;
  logic       s_dack;

  // Bus observation, filled by the monitor.
  logic [31:0] obs_vec;
  int          obs_n;
  int          stop_cnt;

  int         s_cnt;
  logic [7:0] s_shift;
  logic       s_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // What the slave puts on SDA for bit slot cnt (0..7 address, 8 ACK1, 9..16 data, 17 ACK2).
  function automatic logic slave_drive(input int cnt);
    logic m;
    m = (s_shift[7:1] == s_addr);
    if (cnt == 8)                   return m;
    if (cnt >= 9 && cnt <= 16)      return m && s_shift[0] && !s_rdata[16 - cnt];
    if (cnt == 17)                  return m && !s_shift[0] && s_dack;
    return 1'b0;
  endfunction

  // Slave + monitor, evaluated on the falling CLK edge.
  initial begin : mon
    logic scl, sda, p_scl, p_sda;
    p_scl = 1'b1; p_sda = 1'b1;
    s_cnt = 0; s_shift = '0; s_active = 1'b0;
    forever begin
      @(negedge CLK);
      scl = bus_if.m_scl_o;
      sda = bus_sda;
      if (!RESETn) begin
        s_cnt = 0; s_active = 1'b0; s_pull = 1'b0;
      end else begin
        if (p_scl && scl && p_sda && !sda) begin
          s_cnt = 0; s_active = 1'b1; s_shift = '0;
        end
        if (p_scl && scl && !p_sda && sda) stop_cnt++;
        if (!p_scl && scl) begin
          obs_vec = {obs_vec[30:0], sda};
          obs_n++;
          if (s_active) begin
            if (s_cnt < 8) s_shift = {s_shift[6:0], sda};
            s_cnt++;
          end
        end
        if (p_scl && !scl && s_active) s_pull = slave_drive(s_cnt);
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  // Transaction-level expectation: SDA value at every SCL rise, response, latency.
  task automatic model(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       output logic [31:0] e_bits, output int e_n, output logic [1:0] e_nack,
                       output logic [7:0] e_rd, output int e_lat);
    bit   q[$];
    logic hit;
    int   periods;
    hit = (a == s_addr);
    for (int i = 6; i >= 0; i--) q.push_back(a[i]);
    q.push_back(rw);
    q.push_back(!hit);
    if (!hit) begin
      e_nack = 2'b01; e_rd = 8'h00; periods = 11;
    end else begin
      for (int i = 7; i >= 0; i--) q.push_back(rw ? s_rdata[i] : wd[i]);
      q.push_back(rw ? 1'b1 : !s_dack);
      e_nack  = {!rw && !s_dack, 1'b0};
      e_rd    = rw ? s_rdata : 8'h00;
      periods = 20;
    end
    q.push_back(1'b0);
    e_bits = '0;
    foreach (q[i]) e_bits = {e_bits[30:0], q[i]};
    e_n   = q.size();
    e_lat = periods * 4 * CLK_DIV;
  endtask

  // Entered and left on a falling edge; hold keeps cmd_valid asserted through the transfer.
  task automatic do_cmd(input string nm, input logic [6:0] a, input logic rw,
                        input logic [7:0] wd, input bit hold, output int waited);
    logic [31:0] e_bits;
    int          e_n, e_lat, lat, ready_bad;
    logic [1:0]  e_nack;
    logic [7:0]  e_rd;
    model(a, rw, wd, e_bits, e_n, e_nack, e_rd, e_lat);
    waited = 0;
    while (!bus_if.cmd_ready && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
    check({nm, "_ready"}, bus_if.cmd_ready, 1'b1);
    bus_if.cmd_addr  = a;
    bus_if.cmd_rw    = rw;
    bus_if.cmd_wdata = wd;
    bus_if.cmd_valid = 1'b1;
    obs_vec = '0; obs_n = 0; stop_cnt = 0;
    @(posedge CLK);
    @(negedge CLK);
    check({nm, "_busy"}, bus_if.busy, 1'b1);
    if (!hold) bus_if.cmd_valid = 1'b0;
    lat = 0; ready_bad = 0;
    while (!bus_if.rsp_valid && lat < 1000) begin
      if (bus_if.cmd_ready) ready_bad++;
      @(negedge CLK);
      lat++;
    end
    check({nm, "_lat"}, lat, e_lat);
    check({nm, "_rdy_busy"}, ready_bad, 0);
    check({nm, "_busy_rsp"}, bus_if.busy, 1'b1);
    check({nm, "_nack"}, bus_if.rsp_nack, e_nack);
    check({nm, "_rdata"}, bus_if.rsp_rdata, e_rd);
    check({nm, "_nbits"}, obs_n, e_n);
    check({nm, "_bits"}, obs_vec, e_bits);
    check({nm, "_stop"}, stop_cnt, 1);
    @(negedge CLK);
    check({nm, "_pulse"}, bus_if.rsp_valid, 1'b0);
    check({nm, "_idle"}, {bus_if.cmd_ready, bus_if.busy}, 2'b10);
    check({nm, "_hold"}, bus_if.rsp_rdata, e_rd);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int w;
    logic [6:0] ra;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_rw    = 1'b0;
    bus_if.cmd_wdata = '0;
    s_addr = 7'h50; s_rdata = 8'h00; s_dack = 1'b1;
    RESETn = 1'b1;
    #1 RESETn = 1'b0;
    #1;
    check("rst_scl",   bus_if.m_scl_o, 1'b1);
    check("rst_sdaen", bus_if.m_sda_o_en, 1'b0);
    check("rst_ready", bus_if.cmd_ready, 1'b1);
    check("rst_busy",  bus_if.busy, 1'b0);
    check("rst_valid", bus_if.rsp_valid, 1'b0);
    check("rst_rdata", bus_if.rsp_rdata, 8'h00);
    check("rst_nack",  bus_if.rsp_nack, 2'b00);
    check("sda_o",     bus_if.m_sda_o, 1'b0);
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    do_cmd("t1_wr", 7'h50, 1'b0, 8'hA5, 1'b0, w);
    do_cmd("t2_absent", 7'h33, 1'b0, 8'h5A, 1'b0, w);
    s_rdata = 8'h3C;
    do_cmd("t3_rd", 7'h50, 1'b1, 8'h00, 1'b0, w);
    s_addr = 7'h10; s_dack = 1'b0;
    do_cmd("t4_dnack", 7'h10, 1'b0, 8'h0A, 1'b0, w);

    s_addr = 7'h50; s_dack = 1'b1;
    do_cmd("t5_a", 7'h50, 1'b0, 8'h81, 1'b1, w);
    do_cmd("t5_b", 7'h50, 1'b0, 8'h7E, 1'b0, w);
    check("t5_b2b_gap", w, 0);

    // Reset in the middle of RDATA bit 4 (period 14 after accept, quarter 1).
    s_rdata = 8'h3C;
    bus_if.cmd_addr  = 7'h50;
    bus_if.cmd_rw    = 1'b1;
    bus_if.cmd_valid = 1'b1;
    @(posedge CLK);
    #1 bus_if.cmd_valid = 1'b0;
    repeat (114) @(posedge CLK);
    #2;
    check("t6_scl_pre", bus_if.m_scl_o, 1'b0);
    check("t6_rd_pre",  bus_if.rsp_rdata, 8'h03);
    RESETn = 1'b0;
    #1;
    check("t6_scl",   bus_if.m_scl_o, 1'b1);
    check("t6_sdaen", bus_if.m_sda_o_en, 1'b0);
    check("t6_busy",  bus_if.busy, 1'b0);
    check("t6_ready", bus_if.cmd_ready, 1'b1);
    check("t6_rdata", bus_if.rsp_rdata, 8'h00);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    do_cmd("t6_after", 7'h50, 1'b0, 8'hC3, 1'b0, w);

    for (int i = 0; i < 10; i++) begin
      s_addr  = 7'($urandom_range(0, 127));
      s_rdata = 8'($urandom_range(0, 255));
      s_dack  = 1'($urandom_range(0, 1));
      ra      = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : s_addr;
      do_cmd($sformatf("rnd%0d", i), ra, 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
